// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle between pipeline control and div_unit
interface div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             unsig;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;
   logic             overflow;

   modport master (
      output start, unsig, a, b,
      input  busy, done, quotient, remainder, div_zero, overflow
   );

   modport slave (
      input  start, unsig, a, b,
      output busy, done, quotient, remainder, div_zero, overflow
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for MIPS DIV/DIVU (optional macro DIV_FAST_ZERO_EN)
module div_unit #(
   parameter int WIDTH = 32
) (
   input logic        clock,
   input logic        reset,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_r, b_r;        // operands captured on the accepting edge
   logic             unsig_r;
   logic [WIDTH-1:0] dvs;             // divisor magnitude
   logic [WIDTH-1:0] quo;             // dividend shifts out as quotient shifts in
   logic [WIDTH-1:0] rem;             // partial remainder, always below dvs
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg, zero_r, ovf_r;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   shifted, diff;

   // Operand magnitudes and the trial subtraction for the current iteration
   always_comb begin
      abs_a   = (!unsig_r && a_r[WIDTH-1]) ? (~a_r + ONE) : a_r;
      abs_b   = (!unsig_r && b_r[WIDTH-1]) ? (~b_r + ONE) : b_r;
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted - {1'b0, dvs};
   end

   // Control FSM, datapath registers and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         a_r           <= '0;
         b_r           <= '0;
         unsig_r       <= 1'b0;
         dvs           <= '0;
         quo           <= '0;
         rem           <= '0;
         cnt           <= '0;
         q_neg         <= 1'b0;
         r_neg         <= 1'b0;
         zero_r        <= 1'b0;
         ovf_r         <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.quotient  <= '0;
         bus.remainder <= '0;
         bus.div_zero  <= 1'b0;
         bus.overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_r      <= bus.a;
                  b_r      <= bus.b;
                  unsig_r  <= bus.unsig;
                  bus.busy <= 1'b1;
                  state    <= PREP;
               end else begin
                  state <= IDLE;
               end
            end
            PREP: begin
               dvs    <= abs_b;
               quo    <= abs_a;
               rem    <= '0;
               cnt    <= CW'(WIDTH - 1);
               q_neg  <= !unsig_r && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               r_neg  <= !unsig_r && a_r[WIDTH-1];
               zero_r <= (b_r == '0);
               ovf_r  <= !unsig_r && (a_r == MOST_NEG) && (b_r == '1);
`ifdef DIV_FAST_ZERO_EN
               // Zero divisor or dividend: preload what the iteration would produce
               if (b_r == '0 || a_r == '0) begin
                  quo   <= {WIDTH{b_r == '0}};
                  rem   <= abs_a;
                  state <= FIX;
               end else begin
                  state <= ITER;
               end
`else
               state <= ITER;
`endif
            end
            ITER: begin
               if (diff[WIDTH]) begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end else begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            FIX: begin
               bus.quotient  <= q_neg ? (~quo + ONE) : quo;
               bus.remainder <= r_neg ? (~rem + ONE) : rem;
               bus.div_zero  <= zero_r;
               bus.overflow  <= ovf_r;
               bus.busy      <= 1'b0;
               bus.done      <= 1'b1;
               state         <= DONE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit (WIDTH=32)
module tb_div_unit;
   logic clock;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   n;
   int   busy_cnt;
   int   done_seen;

`ifdef DIV_FAST_ZERO_EN
   localparam int ZERO_EDGES = 3;
`else
   localparam int ZERO_EDGES = 35;
`endif

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Counts edges from the accepting edge (edge 1) to the edge after which done is high.
   // pulse_at > 0 re-asserts start with other operands after that edge for one cycle.
   task automatic wait_done(input int pulse_at, output int edges, output int busy_n);
      edges  = 0;
      busy_n = 0;
      do begin
         @(posedge clock);
         #1;
         edges++;
         if (edges == 1) bus.start = 1'b0;
         if (pulse_at > 0 && edges == pulse_at) begin
            bus.start = 1'b1;
            bus.a     = 32'd50;
            bus.b     = 32'd5;
         end
         if (pulse_at > 0 && edges == pulse_at + 1) bus.start = 1'b0;
         if (bus.busy === 1'b1) busy_n++;
      end while (bus.done !== 1'b1 && edges < 100);
   endtask

   task automatic issue(input logic u, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clock);
      bus.start = 1'b1;
      bus.unsig = u;
      bus.a     = av;
      bus.b     = bv;
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.unsig = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_q", bus.quotient, 32'd0);
      chk("reset_r", bus.remainder, 32'd0);
      chk("reset_flags", {30'd0, bus.div_zero, bus.overflow}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // 1: DIVU 100/7, latency and busy length
      issue(1'b1, 32'd100, 32'd7);
      wait_done(0, n, busy_cnt);
      chk("t1_edges", n, 35);
      chk("t1_busy_cycles", busy_cnt, 34);
      chk("t1_q", bus.quotient, 32'd14);
      chk("t1_r", bus.remainder, 32'd2);
      chk("t1_flags", {30'd0, bus.div_zero, bus.overflow}, 32'd0);
      @(posedge clock);
      #1;
      chk("t1_done_pulse", {31'd0, bus.done}, 32'd0);
      repeat (3) @(posedge clock);
      #1;
      chk("t1_hold_idle_q", bus.quotient, 32'd14);

      // 2: signed sign handling
      issue(1'b0, 32'hFFFFFFF9, 32'd2);
      wait_done(0, n, busy_cnt);
      chk("t2a_q", bus.quotient, 32'hFFFFFFFD);
      chk("t2a_r", bus.remainder, 32'hFFFFFFFF);
      issue(1'b0, 32'd7, 32'hFFFFFFFE);
      wait_done(0, n, busy_cnt);
      chk("t2b_q", bus.quotient, 32'hFFFFFFFD);
      chk("t2b_r", bus.remainder, 32'd1);

      // 3: signed overflow, then the same operands unsigned
      issue(1'b0, 32'h80000000, 32'hFFFFFFFF);
      wait_done(0, n, busy_cnt);
      chk("t3a_q", bus.quotient, 32'h80000000);
      chk("t3a_r", bus.remainder, 32'd0);
      chk("t3a_ovf", {31'd0, bus.overflow}, 32'd1);
      chk("t3a_dz", {31'd0, bus.div_zero}, 32'd0);
      issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
      wait_done(0, n, busy_cnt);
      chk("t3b_q", bus.quotient, 32'd0);
      chk("t3b_r", bus.remainder, 32'h80000000);
      chk("t3b_ovf", {31'd0, bus.overflow}, 32'd0);

      // 4: divide by zero
      issue(1'b1, 32'd5, 32'd0);
      wait_done(0, n, busy_cnt);
      chk("t4_edges", n, ZERO_EDGES);
      chk("t4_q", bus.quotient, 32'hFFFFFFFF);
      chk("t4_r", bus.remainder, 32'd5);
      chk("t4_dz", {31'd0, bus.div_zero}, 32'd1);
      chk("t4_ovf", {31'd0, bus.overflow}, 32'd0);

      // 5: start while busy ignored; start held in DONE accepted back-to-back
      issue(1'b1, 32'd100, 32'd7);
      wait_done(10, n, busy_cnt);
      chk("t5a_edges", n, 35);
      chk("t5a_q", bus.quotient, 32'd14);
      chk("t5a_r", bus.remainder, 32'd2);
      chk("t5a_dz", {31'd0, bus.div_zero}, 32'd0);
      bus.start = 1'b1;
      bus.unsig = 1'b1;
      bus.a     = 32'd81;
      bus.b     = 32'd9;
      wait_done(0, n, busy_cnt);
      chk("t5b_edges", n, 35);
      chk("t5b_q", bus.quotient, 32'd9);
      chk("t5b_r", bus.remainder, 32'd0);

      // 6: reset mid-operation, then a fresh op
      issue(1'b1, 32'd1000, 32'd3);
      repeat (20) @(posedge clock);
      #1;
      bus.start = 1'b0;
      reset = 1'b1;
      #1;
      chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("t6_rst_q", bus.quotient, 32'd0);
      chk("t6_rst_r", bus.remainder, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.done === 1'b1) done_seen++;
      end
      chk("t6_no_done", done_seen, 0);
      issue(1'b1, 32'd9, 32'd3);
      wait_done(0, n, busy_cnt);
      chk("t6_edges", n, 35);
      chk("t6_q", bus.quotient, 32'd3);
      chk("t6_r", bus.remainder, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
